// File: rtl/fetch_wf_rr_arbiter.sv
// Round-robin fetch arbiter: picks one ready wavefront, keeps a single
// instruction-memory request outstanding, and reports completion or squash.
module fetch_wf_rr_arbiter #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  wf_ready,
  input  logic               fetch_stall,
  input  logic               mem_ack,
  input  logic               flush_valid,
  input  logic [WF_ID_W-1:0] flush_wf_id,
  output logic               req_valid,
  output logic [WF_ID_W-1:0] req_wf_id,
  output logic [NUM_WF-1:0]  wf_clr,
  output logic               fetch_done,
  output logic [WF_ID_W-1:0] fetch_done_wf_id
);

  typedef enum logic {IDLE, REQ} state_t;

  localparam int PAD_W = 2 ** WF_ID_W;

  state_t               state_q, state_d;
  logic                 req_valid_q, req_valid_d;
  logic [WF_ID_W-1:0]   req_wf_id_q, req_wf_id_d;
  logic [NUM_WF-1:0]    wf_clr_q, wf_clr_d;
  logic                 fetch_done_q, fetch_done_d;
  logic [WF_ID_W-1:0]   fetch_done_wf_id_q, fetch_done_wf_id_d;
  logic                 squash_q, squash_d;
  logic [WF_ID_W-1:0]   last_grant_q, last_grant_d;

  logic [PAD_W-1:0]     ready_pad;
  logic [WF_ID_W:0]     cand;
  logic [WF_ID_W-1:0]   pick_id;
  logic                 flush_hit;

  // Padding the ready vector to 2**WF_ID_W lets a WF_ID_W-bit id index it directly.
  assign ready_pad = PAD_W'(wf_ready);
  assign flush_hit = flush_valid && (flush_wf_id == req_wf_id_q);

  // Circular search from last_grant+1; walking backwards means the nearest
  // ready slot is the last one written.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned and infers a latch.
    cand    = '0;
    pick_id = '0;
    for (int i = NUM_WF; i >= 1; i--) begin
      cand = {1'b0, last_grant_q} + (WF_ID_W+1)'(i);
      if (cand >= (WF_ID_W+1)'(NUM_WF)) cand = cand - (WF_ID_W+1)'(NUM_WF);
      if (ready_pad[cand[WF_ID_W-1:0]]) pick_id = cand[WF_ID_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= IDLE;
      req_valid_q        <= 1'b0;
      req_wf_id_q        <= '0;
      wf_clr_q           <= '0;
      fetch_done_q       <= 1'b0;
      fetch_done_wf_id_q <= '0;
      squash_q           <= 1'b0;
      last_grant_q       <= WF_ID_W'(NUM_WF - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q            <= state_d;
      req_valid_q        <= req_valid_d;
      req_wf_id_q        <= req_wf_id_d;
      wf_clr_q           <= wf_clr_d;
      fetch_done_q       <= fetch_done_d;
      fetch_done_wf_id_q <= fetch_done_wf_id_d;
      squash_q           <= squash_d;
      last_grant_q       <= last_grant_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d            = state_q;
    req_valid_d        = req_valid_q;
    req_wf_id_d        = req_wf_id_q;
    wf_clr_d           = '0;
    fetch_done_d       = 1'b0;
    fetch_done_wf_id_d = fetch_done_wf_id_q;
    squash_d           = squash_q;
    last_grant_d       = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (!fetch_stall && (|wf_ready)) begin
          state_d     = REQ;
          req_valid_d = 1'b1;
          req_wf_id_d = pick_id;
          wf_clr_d    = {{(NUM_WF-1){1'b0}}, 1'b1} << pick_id;
        end
      end
      REQ: begin
        if (flush_hit) squash_d = 1'b1;
        if (mem_ack) begin
          state_d            = IDLE;
          req_valid_d        = 1'b0;
          last_grant_d       = req_wf_id_q;
          fetch_done_d       = !(squash_q || flush_hit);
          fetch_done_wf_id_d = req_wf_id_q;
          squash_d           = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: all outputs come straight from flops.
  always_comb begin
    req_valid        = req_valid_q;
    req_wf_id        = req_wf_id_q;
    wf_clr           = wf_clr_q;
    fetch_done       = fetch_done_q;
    fetch_done_wf_id = fetch_done_wf_id_q;
  end

endmodule

// File: tb/tb_fetch_wf_rr_arbiter.sv
// Scoreboard bench for fetch_wf_rr_arbiter: the driver pushes predicted grants
// and completions, a negedge monitor pops and compares them.
module tb_fetch_wf_rr_arbiter;

  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;

  typedef struct {
    bit             done;
    int             id;
  } done_exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_WF-1:0]  wf_ready = '0;
  logic               fetch_stall = 1'b0;
  logic               mem_ack = 1'b0;
  logic               flush_valid = 1'b0;
  logic [WF_ID_W-1:0] flush_wf_id = '0;
  logic               req_valid;
  logic [WF_ID_W-1:0] req_wf_id;
  logic [NUM_WF-1:0]  wf_clr;
  logic               fetch_done;
  logic [WF_ID_W-1:0] fetch_done_wf_id;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        grant_q[$];
  done_exp_t done_q[$];
  int        grant_log[$];
  int        model_last = NUM_WF - 1;

  fetch_wf_rr_arbiter #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .wf_ready         (wf_ready),
    .fetch_stall      (fetch_stall),
    .mem_ack          (mem_ack),
    .flush_valid      (flush_valid),
    .flush_wf_id      (flush_wf_id),
    .req_valid        (req_valid),
    .req_wf_id        (req_wf_id),
    .wf_clr           (wf_clr),
    .fetch_done       (fetch_done),
    .fetch_done_wf_id (fetch_done_wf_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference pick: the lowest ready id above the last grant, else the lowest ready id.
  function automatic int model_pick(input logic [NUM_WF-1:0] rdy, input int last);
    int ids[$];
    for (int i = 0; i < NUM_WF; i++) if (rdy[i]) ids.push_back(i);
    foreach (ids[k]) if (ids[k] > last) return ids[k];
    return ids[0];
  endfunction

  function automatic logic [NUM_WF-1:0] rand_ready();
    logic [NUM_WF-1:0] r;
    r = NUM_WF'({$urandom, $urandom}) & NUM_WF'({$urandom, $urandom});
    if ($urandom_range(0, 2) == 0) r = r & NUM_WF'({$urandom, $urandom});
    return r;
  endfunction

  // One arbitration attempt, entered and left at a falling edge.
  // fmode: 0 none, 1 flush owner before ack, 2 flush owner with ack, 3 flush other id with ack.
  task automatic txn(input logic [NUM_WF-1:0] rdy, input bit stall, input int w,
                     input int fmode, input bit mid_rst);
    int        winner;
    done_exp_t de;
    wf_ready    = rdy;
    fetch_stall = stall;
    mem_ack     = 1'b0;
    flush_valid = 1'b0;
    if (stall || rdy == '0) begin
      if ($urandom_range(0, 3) == 0) begin
        flush_valid = 1'b1;
        flush_wf_id = WF_ID_W'($urandom_range(0, NUM_WF - 1));
      end
      if ($urandom_range(0, 3) == 0) mem_ack = 1'b1;
      @(negedge clk);
      flush_valid = 1'b0;
      mem_ack     = 1'b0;
      return;
    end
    winner = model_pick(rdy, model_last);
    grant_q.push_back(winner);
    @(negedge clk);
    for (int i = 0; i < w; i++) begin
      flush_valid = (fmode == 1 && i == 0);
      flush_wf_id = WF_ID_W'(winner);
      wf_ready    = rand_ready();
      fetch_stall = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    flush_valid = 1'b0;
    if (mid_rst) begin
      wf_ready = '0;
      #2 rst = 1'b1;
      #1 check("async_rst_req_valid", 64'(req_valid), 64'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      model_last = NUM_WF - 1;
      @(negedge clk);
      return;
    end
    mem_ack = 1'b1;
    if (fmode == 2) begin
      flush_valid = 1'b1;
      flush_wf_id = WF_ID_W'(winner);
    end else if (fmode == 3) begin
      flush_valid = 1'b1;
      flush_wf_id = WF_ID_W'((winner + 1 + int'($urandom_range(0, NUM_WF - 2))) % NUM_WF);
    end
    de.done = !((fmode == 1 && w >= 1) || fmode == 2);
    de.id   = winner;
    done_q.push_back(de);
    model_last = winner;
    @(negedge clk);
    mem_ack     = 1'b0;
    flush_valid = 1'b0;
    wf_ready    = '0;
  endtask

  // Monitor: pops expectations on request rise (grant) and fall (completion).
  initial begin
    bit        prev_valid = 1'b0;
    int        prev_id = 0;
    int        e;
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (req_valid && !prev_valid) begin
          if (grant_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_req: got id %0d, expected no request", req_wf_id);
          end else begin
            e = grant_q.pop_front();
            check("req_wf_id", 64'(req_wf_id), 64'(e));
            check("wf_clr_onehot", 64'(wf_clr), 64'(1) << e);
            grant_log.push_back(int'(req_wf_id));
          end
        end else begin
          check("wf_clr_quiet", 64'(wf_clr), 64'd0);
        end
        if (prev_valid && req_valid) check("req_wf_id_hold", 64'(req_wf_id), 64'(prev_id));
        if (prev_valid && !req_valid) begin
          if (done_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL spurious_release: got fetch_done %0d, expected request held", fetch_done);
          end else begin
            de = done_q.pop_front();
            check("fetch_done", 64'(fetch_done), 64'(de.done));
            if (de.done) check("fetch_done_wf_id", 64'(fetch_done_wf_id), 64'(de.id));
          end
        end else begin
          check("fetch_done_quiet", 64'(fetch_done), 64'd0);
        end
        prev_valid = req_valid;
        prev_id    = int'(req_wf_id);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_WF-1:0] r;
    wf_ready = '1;
    mem_ack  = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_req_wf_id", 64'(req_wf_id), 64'd0);
    check("rst_wf_clr", 64'(wf_clr), 64'd0);
    check("rst_fetch_done", 64'(fetch_done), 64'd0);
    check("rst_fetch_done_wf_id", 64'(fetch_done_wf_id), 64'd0);
    wf_ready = '0;
    mem_ack  = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);

    txn(40'h1, 1'b0, 1, 0, 1'b0);
    r = '0; r[2] = 1'b1; r[5] = 1'b1; r[39] = 1'b1;
    repeat (4) txn(r, 1'b0, 2, 0, 1'b0);
    check("order_len", 64'(grant_log.size()), 64'd5);
    if (grant_log.size() >= 5) begin
      check("order_0", 64'(grant_log[1]), 64'd2);
      check("order_1", 64'(grant_log[2]), 64'd5);
      check("order_2", 64'(grant_log[3]), 64'd39);
      check("order_3", 64'(grant_log[4]), 64'd2);
    end

    r = '0; r[39] = 1'b1;
    txn(r, 1'b0, 0, 0, 1'b0);
    repeat (5) txn(40'hFF, 1'b1, 0, 0, 1'b0);
    txn(40'hFF, 1'b0, 1, 0, 1'b0);

    r = '0; r[7] = 1'b1;
    txn(r, 1'b0, 2, 1, 1'b0);
    txn(r, 1'b0, 2, 2, 1'b0);
    r = '0; r[3] = 1'b1; r[7] = 1'b1; r[8] = 1'b1;
    txn(r, 1'b0, 1, 0, 1'b0);

    r = '0; r[12] = 1'b1;
    txn(r, 1'b0, 2, 0, 1'b1);
    r[0] = 1'b1;
    txn(r, 1'b0, 1, 0, 1'b0);

    for (int n = 0; n < 200; n++) begin
      r = ($urandom_range(0, 9) == 0) ? '0 : rand_ready();
      txn(r, $urandom_range(0, 4) == 0, int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (4) @(negedge clk);
    check("grant_q_drained", 64'(grant_q.size()), 64'd0);
    check("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
